// File: rtl/fc_layer_tm.sv
// fc_layer_tm: time-multiplexed fully-connected layer.
// NUM_OUTPUTS neurons on NUM_PES shared MAC lanes, P = NUM_OUTPUTS/NUM_PES passes.
// Ports: CLK, RSTN (async, active-low); W_WEN/W_ADDR/W_DATA coefficient write,
//   address o*(NUM_INPUTS+1)+i, i=NUM_INPUTS is the bias of neuron o;
//   VALUE_IN/VALID_IN/READY input stream; VALUES_OUT/VALID_OUT/OUT_READY
//   held result vector; OVERFLOW sticky per frame; BUSY outside IDLE.
// Macro FC_LAYER_SAT_EN: clamp out-of-range results (default: keep low bits).
`timescale 1ns/1ps

module fc_layer_tm #(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_OUTPUTS = 4,
    parameter int NUM_PES     = 2,
    parameter int WIDTH       = 8,
    parameter int FRAC_BITS   = 3
) (
    input  logic                                         CLK,
    input  logic                                         RSTN,
    input  logic                                         W_WEN,
    input  logic [$clog2(NUM_OUTPUTS*(NUM_INPUTS+1))-1:0] W_ADDR,
    input  logic signed [WIDTH-1:0]                      W_DATA,
    output logic                                         READY,
    input  logic signed [WIDTH-1:0]                      VALUE_IN,
    input  logic                                         VALID_IN,
    output logic [NUM_OUTPUTS*WIDTH-1:0]                 VALUES_OUT,
    output logic                                         VALID_OUT,
    input  logic                                         OUT_READY,
    output logic                                         OVERFLOW,
    output logic                                         BUSY
);

    localparam int P     = NUM_OUTPUTS / NUM_PES;
    localparam int NROW  = NUM_INPUTS + 1;
    localparam int NCOEF = NUM_OUTPUTS * NROW;
    localparam int AW    = $clog2(NCOEF);
    localparam int CW    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int PW    = (P > 1) ? $clog2(P) : 1;
    localparam int OW    = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int ACCW  = 2*WIDTH + $clog2(NUM_INPUTS+1);

    localparam logic signed [ACCW-1:0]  R_MAX   = ACCW'((2**(WIDTH-1)) - 1);
    localparam logic signed [ACCW-1:0]  R_MIN   = ~R_MAX;
    localparam logic signed [WIDTH-1:0] O_MAX   = R_MAX[WIDTH-1:0];
    localparam logic signed [WIDTH-1:0] O_MIN   = ~O_MAX;
    localparam logic [AW:0]             NCOEF_V = (AW+1)'(NCOEF);
    localparam logic [CW-1:0]           LAST_I  = CW'(NUM_INPUTS-1);
    localparam logic [PW-1:0]           LAST_P  = PW'(P-1);

    typedef enum logic [1:0] {
        S_IDLE, S_COMPUTE, S_WRITEBACK, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pass_q, pass_d;
    logic ovf_q, ovf_d;
    logic signed [WIDTH-1:0] w_q [NCOEF];
    logic signed [WIDTH-1:0] w_d [NCOEF];
    logic signed [WIDTH-1:0] x_q [NUM_INPUTS];
    logic signed [WIDTH-1:0] x_d [NUM_INPUTS];
    logic signed [ACCW-1:0] acc_q [NUM_PES];
    logic signed [ACCW-1:0] acc_d [NUM_PES];
    logic signed [WIDTH-1:0] out_q [NUM_OUTPUTS];
    logic signed [WIDTH-1:0] out_d [NUM_OUTPUTS];

    logic load;
    logic [PW-1:0] pass_ld;
    logic [AW-1:0] widx;
    logic [OW-1:0] oidx;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0] r;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        ovf_d   = ovf_q;
        w_d     = w_q;
        x_d     = x_q;
        acc_d   = acc_q;
        out_d   = out_q;
        load    = 1'b0;
        pass_ld = '0;
        widx    = '0;
        oidx    = '0;
        prod    = '0;
        r       = '0;
        unique case (state_q)
            S_IDLE: begin
                // Coefficients may only change between frames.
                if (W_WEN && cnt_q == '0 && {1'b0, W_ADDR} < NCOEF_V)
                    w_d[W_ADDR] = W_DATA;
                if (VALID_IN) begin
                    x_d[cnt_q] = VALUE_IN;
                    if (cnt_q == '0)
                        ovf_d = 1'b0;
                    if (cnt_q == LAST_I) begin
                        cnt_d   = '0;
                        pass_d  = '0;
                        load    = 1'b1;
                        state_d = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                for (int k = 0; k < NUM_PES; k++) begin
                    widx = AW'((int'(pass_q)*NUM_PES + k)*NROW + int'(cnt_q));
                    prod = (2*WIDTH)'(x_q[cnt_q]) * (2*WIDTH)'(w_q[widx]);
                    acc_d[k] = acc_q[k] + ACCW'(prod);
                end
                if (cnt_q == LAST_I) begin
                    cnt_d   = '0;
                    state_d = S_WRITEBACK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WRITEBACK: begin
                for (int k = 0; k < NUM_PES; k++) begin
                    oidx = OW'(int'(pass_q)*NUM_PES + k);
                    r = acc_q[k] >>> FRAC_BITS;
                    out_d[oidx] = r[WIDTH-1:0];
                    if (r > R_MAX) begin
                        ovf_d = 1'b1;
`ifdef FC_LAYER_SAT_EN
                        out_d[oidx] = O_MAX;
`endif
                    end else if (r < R_MIN) begin
                        ovf_d = 1'b1;
`ifdef FC_LAYER_SAT_EN
                        out_d[oidx] = O_MIN;
`endif
                    end
                end
                if (pass_q == LAST_P) begin
                    state_d = S_DONE;
                end else begin
                    pass_d  = pass_q + PW'(1);
                    pass_ld = pass_q + PW'(1);
                    load    = 1'b1;
                    state_d = S_COMPUTE;
                end
            end
            S_DONE: begin
                if (OUT_READY)
                    state_d = S_IDLE;
            end
        endcase
        // Seed each lane with its bias, aligned to the product's fraction.
        if (load) begin
            for (int k = 0; k < NUM_PES; k++) begin
                widx = AW'((int'(pass_ld)*NUM_PES + k)*NROW + NUM_INPUTS);
                acc_d[k] = ACCW'(w_q[widx]) <<< FRAC_BITS;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pass_q  <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NCOEF; i++) w_q[i] <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) x_q[i] <= '0;
            for (int i = 0; i < NUM_PES; i++) acc_q[i] <= '0;
            for (int i = 0; i < NUM_OUTPUTS; i++) out_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            ovf_q   <= ovf_d;
            w_q     <= w_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign READY     = (state_q == S_IDLE);
    assign BUSY      = (state_q != S_IDLE);
    assign VALID_OUT = (state_q == S_DONE);
    assign OVERFLOW  = ovf_q;

    always_comb begin
        VALUES_OUT = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++)
            VALUES_OUT[o*WIDTH +: WIDTH] = out_q[o];
    end

endmodule

// File: tb/tb_fc_layer_tm.sv
// tb_fc_layer_tm: vector table plus corner sequences for fc_layer_tm
// (NUM_INPUTS=2, NUM_OUTPUTS=4, NUM_PES=2, WIDTH=8, FRAC_BITS=3).
`timescale 1ns/1ps

module tb_fc_layer_tm;

    localparam int NV = 7;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic W_WEN = 1'b0;
    logic [3:0] W_ADDR = '0;
    logic signed [7:0] W_DATA = '0;
    logic READY;
    logic signed [7:0] VALUE_IN = '0;
    logic VALID_IN = 1'b0;
    logic [31:0] VALUES_OUT;
    logic VALID_OUT;
    logic OUT_READY = 1'b0;
    logic OVERFLOW;
    logic BUSY;

    fc_layer_tm #(
        .NUM_INPUTS(2), .NUM_OUTPUTS(4), .NUM_PES(2),
        .WIDTH(8), .FRAC_BITS(3)
    ) dut (
        .CLK(CLK), .RSTN(RSTN),
        .W_WEN(W_WEN), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
        .READY(READY), .VALUE_IN(VALUE_IN), .VALID_IN(VALID_IN),
        .VALUES_OUT(VALUES_OUT), .VALID_OUT(VALID_OUT),
        .OUT_READY(OUT_READY), .OVERFLOW(OVERFLOW), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

`ifdef FC_LAYER_SAT_EN
    localparam logic [31:0] OVP = 32'h7F7F7F7F;
    localparam logic [31:0] OVN = 32'h80808080;
`else
    localparam logic [31:0] OVP = 32'hC0C0C0C0;
    localparam logic [31:0] OVN = 32'h20202020;
`endif

    typedef struct {
        logic [95:0] coef;
        logic [7:0]  x0;
        logic [7:0]  x1;
        logic [31:0] vals;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] vals;
        logic        ovf;
    } exp_t;

    vec_t tv [NV];
    exp_t sb [$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;
    int out_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [95:0] uni(input logic [7:0] w,
                                        input logic [7:0] b);
        logic [95:0] c;
        c = '0;
        for (int o = 0; o < 4; o++) begin
            c[(o*3)*8 +: 8]   = w;
            c[(o*3+1)*8 +: 8] = w;
            c[(o*3+2)*8 +: 8] = b;
        end
        return c;
    endfunction

    task automatic push(input logic [31:0] v, input logic o);
        exp_t e;
        e.vals = v;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        W_WEN  = 1'b1;
        W_ADDR = a[3:0];
        W_DATA = d;
        tick();
        W_WEN  = 1'b0;
    endtask

    task automatic load(input logic [95:0] c);
        for (int a = 0; a < 12; a++)
            wr(a, c[a*8 +: 8]);
    endtask

    task automatic accept(input logic [7:0] v);
        int n;
        n = 0;
        VALID_IN = 1'b1;
        VALUE_IN = v;
        while (!READY && n < 100) begin
            tick();
            n++;
        end
        if (!READY) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got READY=0, expected 1");
        end
        tick();
        VALID_IN = 1'b0;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b);
        accept(a);
        accept(b);
    endtask

    task automatic wait_out();
        int start;
        int n;
        start = out_cnt;
        n = 0;
        while (out_cnt == start && n < 100) begin
            tick();
            n++;
        end
        if (out_cnt == start) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: got no result, expected one");
        end
    endtask

    // Scoreboard: every accepted result vector is matched in order.
    always @(negedge CLK) begin
        if (RSTN && VALID_OUT && OUT_READY) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h, expected none",
                         VALUES_OUT);
            end else begin
                mon_e = sb.pop_front();
                chk("values_out", VALUES_OUT, mon_e.vals);
                chk("overflow", 32'(OVERFLOW), 32'(mon_e.ovf));
            end
            out_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [95:0] c;
        int n;

        tv[0] = '{uni(8'd8, 8'd0), 8'd8, 8'd16, 32'h18181818, 1'b0};
        c = '0;
        c[0 +: 8]  = 8'd4;
        c[24 +: 8] = 8'hF8;
        c[64 +: 8] = 8'd2;
        tv[1] = '{c, 8'd3, 8'd0, 32'h0002FD01, 1'b0};
        tv[2] = '{c, 8'hFD, 8'd0, 32'h000203FE, 1'b0};
        tv[3] = '{uni(8'd127, 8'd0), 8'd127, 8'd127, OVP, 1'b1};
        tv[4] = '{uni(8'd8, 8'd0), 8'd8, 8'd16, 32'h18181818, 1'b0};
        tv[5] = '{uni(8'd127, 8'd0), 8'h80, 8'h80, OVN, 1'b1};
        c = '0;
        for (int o = 0; o < 4; o++) begin
            c[(o*3)*8 +: 8]   = 8'(o+1);
            c[(o*3+1)*8 +: 8] = 8'(o+1);
            c[(o*3+2)*8 +: 8] = 8'hFF;
        end
        tv[6] = '{c, 8'd10, 8'd20, 32'h0E0A0602, 1'b0};

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready", 32'(READY), 32'd1);
        chk("rst_valid", 32'(VALID_OUT), 32'd0);
        chk("rst_values", VALUES_OUT, 32'd0);
        chk("rst_ovf", 32'(OVERFLOW), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        RSTN = 1'b1;
        tick();
        OUT_READY = 1'b1;

        for (int v = 0; v < NV; v++) begin
            load(tv[v].coef);
            push(tv[v].vals, tv[v].ovf);
            frame(tv[v].x0, tv[v].x1);
            wait_out();
        end

        // Latency from the last accept to VALID_OUT.
        load(uni(8'd8, 8'd0));
        push(32'h18181818, 1'b0);
        accept(8'd8);
        accept(8'd16);
        chk("busy_after_last", 32'(BUSY), 32'd1);
        chk("ready_after_last", 32'(READY), 32'd0);
        n = 0;
        while (!VALID_OUT && n < 50) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'd6);
        wait_out();
        chk("ready_after_hs", 32'(READY), 32'd1);

        // Backpressure in DONE with overflowed results held.
        load(uni(8'd127, 8'd0));
        OUT_READY = 1'b0;
        push(OVP, 1'b1);
        frame(8'd127, 8'd127);
        n = 0;
        while (!VALID_OUT && n < 50) begin
            tick();
            n++;
        end
        VALID_IN = 1'b1;
        VALUE_IN = 8'd55;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("bp_values", VALUES_OUT, OVP);
            chk("bp_ready", 32'(READY), 32'd0);
            chk("bp_valid", 32'(VALID_OUT), 32'd1);
            chk("bp_ovf", 32'(OVERFLOW), 32'd1);
            tick();
        end
        VALID_IN  = 1'b0;
        OUT_READY = 1'b1;
        tick();
        chk("ready_after_bp", 32'(READY), 32'd1);
        chk("ovf_held_idle", 32'(OVERFLOW), 32'd1);
        load(uni(8'd8, 8'd0));
        push(32'h18181818, 1'b0);
        accept(8'd8);
        chk("ovf_cleared", 32'(OVERFLOW), 32'd0);
        accept(8'd16);
        wait_out();

        // Coefficient writes are dropped outside IDLE and out of range.
        push(32'h18181818, 1'b0);
        frame(8'd8, 8'd16);
        wr(0, 8'hFF);
        wait_out();
        wr(13, 8'd100);
        wr(0, 8'hFF);
        push(32'h1818180F, 1'b0);
        frame(8'd8, 8'd16);
        wait_out();

        // Asynchronous reset in the middle of a pass.
        frame(8'd8, 8'd16);
        tick();
        RSTN = 1'b0;
        #1;
        chk("mid_rst_values", VALUES_OUT, 32'd0);
        chk("mid_rst_ready", 32'(READY), 32'd1);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        chk("mid_rst_valid", 32'(VALID_OUT), 32'd0);
        tick();
        RSTN = 1'b1;
        tick();
        push(32'd0, 1'b0);
        frame(8'd8, 8'd16);
        wait_out();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_layer_tm.md
# fc_layer_tm

Time-multiplexed fully-connected layer: the next generation of the per-neuron hidden layer. It computes NUM_OUTPUTS neurons on NUM_PES shared multiply-accumulate lanes over several passes. Weights and biases live in an internal register file loaded through a parallel write port. A frame of NUM_INPUTS values is streamed in with a ready/valid handshake. The result vector is held until the downstream layer accepts it.

## Interface
- NUM_INPUTS, 4: inputs per frame (≥1)
- NUM_OUTPUTS, 4: neurons (≥1, multiple of NUM_PES)
- NUM_PES, 2: parallel MAC lanes; passes P = NUM_OUTPUTS/NUM_PES
- WIDTH, 8: signed fixed-point data width
- FRAC_BITS, 3: fractional bits
- CLK  in  1  single clock, rising edge
- RSTN  in  1  reset, asynchronous, active-low
- W_WEN  in  1  weight/bias write strobe
- W_ADDR  in  clog2(NUM_OUTPUTS*(NUM_INPUTS+1))  address: o*(NUM_INPUTS+1)+i; i=NUM_INPUTS is bias of neuron o
- W_DATA  in  WIDTH  signed coefficient
- READY  out  1  high in IDLE; input accepted on VALID_IN&READY
- VALUE_IN  in  WIDTH  signed input sample
- VALID_IN  in  1  input valid
- VALUES_OUT  out  NUM_OUTPUTS*WIDTH  neuron o at [o*WIDTH +: WIDTH]
- VALID_OUT  out  1  result vector valid, held until OUT_READY
- OUT_READY  in  1  downstream accept
- OVERFLOW  out  1  any neuron of the current frame out of range
- BUSY  out  1  high in COMPUTE/WRITEBACK/DONE

## Operation
- FSM: IDLE → COMPUTE → WRITEBACK → (COMPUTE for next pass | DONE) → IDLE.
- IDLE: each accepted input is stored in input buffer x[cnt] and cnt increments. The first accept of a frame clears OVERFLOW. On acceptance of x[NUM_INPUTS-1]: cnt=0, pass=0, state→COMPUTE, and lane k's acc is set to bias[k] <<< FRAC_BITS (sign-extended).
- COMPUTE: one input index i per cycle, i=0..NUM_INPUTS-1. acc[k] += x[i]*w[pass*NUM_PES+k][i]. After i=NUM_INPUTS-1, state→WRITEBACK.
- WRITEBACK: r = acc[k] >>> FRAC_BITS (arithmetic; truncates toward −inf). The result is written to output register pass*NUM_PES+k. If r is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1], OVERFLOW is set (sticky for the frame). If pass<P−1: pass++, accumulators reload the next biases, state→COMPUTE. Otherwise state→DONE.
- DONE: VALID_OUT=1. VALUES_OUT and OVERFLOW stay stable. On OUT_READY: state→IDLE, VALID_OUT=0 next cycle.
- Widths: product 2*WIDTH; acc is 2*WIDTH+clog2(NUM_INPUTS+1) bits, so no internal wrap occurs.
- Weight writes take effect only in IDLE with cnt=0. Writes in any other state, and writes with W_ADDR ≥ NUM_OUTPUTS*(NUM_INPUTS+1), are dropped silently.
- VALID_IN while READY=0 is ignored; no data is latched.
- Reset (any state, including mid-frame): state=IDLE, cnt=pass=0, all weights/biases/inputs/accumulators=0.

## Timing
- Reset values: READY=1, VALID_OUT=0, VALUES_OUT=0, OVERFLOW=0, BUSY=0.
- Last input accepted at edge T. VALID_OUT rises at edge T+P*(NUM_INPUTS+1), i.e. P*(NUM_INPUTS+1) cycles of latency.
- READY falls at edge T and returns one cycle after the OUT_READY handshake. VALID_OUT&OUT_READY in the same cycle completes the frame, and the next input may be accepted the following cycle.
- Throughput: one frame per NUM_INPUTS + P*(NUM_INPUTS+1) + 1 cycles minimum.

## Configuration
- FC_LAYER_SAT_EN defined: an out-of-range r is clamped to 2^(WIDTH−1)−1 or −2^(WIDTH−1).
- FC_LAYER_SAT_EN undefined: the low WIDTH bits of r are kept (wrap).
- OVERFLOW reporting is identical in both cases.

## Test plan
All scenarios use NUM_INPUTS=2, NUM_OUTPUTS=4, NUM_PES=2, WIDTH=8, FRAC_BITS=3.
- Basic: all weights 8 (1.0), biases 0, inputs 8,16 → all four outputs 24, OVERFLOW=0, VALID_OUT exactly 6 cycles after second accept.
- Sign/truncation: neuron0 w=(4,0), neuron1 w=(−8,0), bias 2 on neuron2 only, x=(3,0) → outputs 1, −3, 2, 0. Repeat with x=(−3,0) → −2, 3, 2, 0.
- Overflow: all weights 127, inputs 127,127 → r=4032. With FC_LAYER_SAT_EN: outputs 127. Without: outputs −64. OVERFLOW=1 in both; cleared on the next frame's first accept.
- Backpressure: hold OUT_READY=0 for 10 cycles in DONE with VALID_IN=1 → VALUES_OUT stable, READY=0, no input latched; OUT_READY=1 → READY=1 next cycle.
- Write gating: W_WEN to address 0 with W_DATA=−1 during COMPUTE → result unchanged from scenario 1; same write in IDLE → neuron0 on the next frame = (−1*8+8*16)>>>3 = 15.
- Reset mid-COMPUTE: drop RSTN → VALUES_OUT=0, READY=1, BUSY=0 immediately; a fresh frame with zeroed weights yields all 0.
